uart_transmitter: RTL and testbench

UART transmit engine: pops bytes from the TX FIFO and serializes them onto `Tx_Serial` as start bit, LSB-first data, optional parity, and stop bits, timed by an internal baud divider. It sits between the TX FIFO and the pad and is the transmit counterpart of the receive path and RX FIFO. It shares `BIST_Mode` with the receive side.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_baud_gen.sv | 29 ++
 rtl/uart_transmitter.sv | 136 +++++++++++++
 tb/tb_uart_transmitter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM encoding, default frame constants and frame length.
// Build option UART_TX_PARITY_EN adds the PARITY state and one parity bit per frame.
package uart_pkg;

   localparam int DEF_DATA_BITS    = 8;
   localparam int DEF_CLKS_PER_BIT = 16;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   typedef enum logic [2:0] {
      TX_IDLE   = ST_IDLE,
      TX_START  = ST_START,
      TX_DATA   = ST_DATA,
`ifdef UART_TX_PARITY_EN
      TX_PARITY = ST_PARITY,
`endif
      TX_STOP   = ST_STOP
   } tx_state_t;

   function automatic int frame_bits(input int data_bits, input int stop_bits);
`ifdef UART_TX_PARITY_EN
      return 1 + data_bits + 1 + stop_bits;
`else
      return 1 + data_bits + stop_bits;
`endif
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Independent of UART_TX_PARITY_EN.
module uart_baud_gen #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic Clk,
   input  logic Rst,
   input  logic Clear,
   output logic Bit_Tick
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] baud_cnt;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         baud_cnt <= '0;
      end else if (Clear || (baud_cnt == LAST)) begin
         baud_cnt <= '0;
      end else begin
         baud_cnt <= baud_cnt + CNT_W'(1);
      end
   end

   assign Bit_Tick = (baud_cnt == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// UART transmit engine: pops the TX FIFO head and serializes start, LSB-first data, parity, stop.
// Define UART_TX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD).
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int DATA_BITS    = DEF_DATA_BITS,
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
   parameter int STOP_BITS    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic [DATA_BITS-1:0] Tx_Data,
   input  logic                 Tx_Valid,
   input  logic                 BIST_Mode,
   output logic                 Tx_Read,
   output logic                 Tx_Serial,
   output logic                 Tx_Busy,
   output logic                 Tx_Done
);

   localparam int BC_W = $clog2(DATA_BITS + 1);

   tx_state_t            state;
   logic [DATA_BITS-1:0] shift_reg;
   logic [BC_W-1:0]      bit_cnt;
   logic                 bit_tick;
   logic                 frame_end;
   logic                 load;

`ifdef UART_TX_PARITY_EN
   logic                 parity_bit;
`else
   logic                 unused_parity_odd;
   assign unused_parity_odd = 1'(PARITY_ODD);
`endif

   uart_baud_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .Clk      (Clk),
      .Rst      (Rst),
      .Clear    (state == TX_IDLE),
      .Bit_Tick (bit_tick)
   );

   // The stop counter reuses bit_cnt; a frame may chain straight into the next start bit.
   assign frame_end = (state == TX_STOP) && bit_tick && (bit_cnt == BC_W'(STOP_BITS - 1));
   assign load      = ((state == TX_IDLE) || frame_end) && Tx_Valid && !BIST_Mode;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state      <= TX_IDLE;
         shift_reg  <= '0;
         bit_cnt    <= '0;
         Tx_Serial  <= 1'b1;
         Tx_Read    <= 1'b0;
         Tx_Busy    <= 1'b0;
         Tx_Done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         Tx_Read <= 1'b0;
         Tx_Done <= frame_end;
         if (load) begin
            state      <= TX_START;
            shift_reg  <= Tx_Data;
            bit_cnt    <= '0;
            Tx_Serial  <= 1'b0;
            Tx_Read    <= 1'b1;
            Tx_Busy    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_bit <= (^Tx_Data) ^ 1'(PARITY_ODD);
`endif
         end else begin
            case (state)
               TX_IDLE: begin
                  Tx_Serial <= 1'b1;
                  Tx_Busy   <= 1'b0;
               end
               TX_START: begin
                  if (bit_tick) begin
                     state     <= TX_DATA;
                     Tx_Serial <= shift_reg[0];
                     shift_reg <= shift_reg >> 1;
                     bit_cnt   <= BC_W'(1);
                  end
               end
               TX_DATA: begin
                  if (bit_tick) begin
                     if (bit_cnt == BC_W'(DATA_BITS)) begin
                        bit_cnt   <= '0;
`ifdef UART_TX_PARITY_EN
                        state     <= TX_PARITY;
                        Tx_Serial <= parity_bit;
`else
                        state     <= TX_STOP;
                        Tx_Serial <= 1'b1;
`endif
                     end else begin
                        Tx_Serial <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        bit_cnt   <= bit_cnt + BC_W'(1);
                     end
                  end
               end
`ifdef UART_TX_PARITY_EN
               TX_PARITY: begin
                  if (bit_tick) begin
                     state     <= TX_STOP;
                     Tx_Serial <= 1'b1;
                  end
               end
`endif
               TX_STOP: begin
                  if (frame_end) begin
                     state     <= TX_IDLE;
                     bit_cnt   <= '0;
                     Tx_Serial <= 1'b1;
                     Tx_Busy   <= 1'b0;
                  end else if (bit_tick) begin
                     bit_cnt   <= bit_cnt + BC_W'(1);
                  end
               end
               default: begin
                  state     <= TX_IDLE;
                  Tx_Serial <= 1'b1;
                  Tx_Busy   <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter at CLKS_PER_BIT=4; frame is 44 cycles with or without
// UART_TX_PARITY_EN (1 stop bit with parity, 2 without).
module tb_uart_transmitter;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int STOPS = 1;
`else
   localparam int STOPS = 2;
`endif
   localparam int FRAME = CPB * 11;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] tx_data, tx_data2;
   logic       tx_valid, tx_valid2, bist;
   logic       tx_read, tx_serial, tx_busy, tx_done;
   logic       tx_read2, tx_serial2, tx_busy2, tx_done2;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   uart_transmitter #(
      .DATA_BITS (8), .CLKS_PER_BIT (CPB), .STOP_BITS (STOPS), .PARITY_ODD (0)
   ) dut (
      .Clk (clk), .Rst (rst), .Tx_Data (tx_data), .Tx_Valid (tx_valid), .BIST_Mode (bist),
      .Tx_Read (tx_read), .Tx_Serial (tx_serial), .Tx_Busy (tx_busy), .Tx_Done (tx_done)
   );

   uart_transmitter #(
      .DATA_BITS (8), .CLKS_PER_BIT (CPB), .STOP_BITS (STOPS), .PARITY_ODD (1)
   ) dut_odd (
      .Clk (clk), .Rst (rst), .Tx_Data (tx_data2), .Tx_Valid (tx_valid2), .BIST_Mode (1'b0),
      .Tx_Read (tx_read2), .Tx_Serial (tx_serial2), .Tx_Busy (tx_busy2), .Tx_Done (tx_done2)
   );

   // Expected line level during bit period k of a frame carrying d.
   function automatic logic exp_bit(input logic [7:0] d, input logic odd, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return d[k-1];
`ifdef UART_TX_PARITY_EN
      if (k == 9) return (^d) ^ odd;
`endif
      return 1'b1;
   endfunction

   task automatic test_reset();
      rst = 1'b1; tx_valid = 1'b0; tx_valid2 = 1'b0; bist = 1'b0;
      tx_data = 8'h00; tx_data2 = 8'h00;
      repeat (3) @(negedge clk);
      n_tests++; if (tx_serial !== 1'b1) begin n_fail++; $display("FAIL reset serial got %b exp 1", tx_serial); end
      n_tests++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset busy got %b exp 0", tx_busy); end
      n_tests++; if (tx_read !== 1'b0) begin n_fail++; $display("FAIL reset read got %b exp 0", tx_read); end
      n_tests++; if (tx_done !== 1'b0) begin n_fail++; $display("FAIL reset done got %b exp 0", tx_done); end
      n_tests++; if (tx_serial2 !== 1'b1) begin n_fail++; $display("FAIL reset serial2 got %b exp 1", tx_serial2); end
      rst = 1'b0;
      @(negedge clk);
      n_tests++; if (tx_serial !== 1'b1 || tx_busy !== 1'b0) begin
         n_fail++; $display("FAIL idle_after_reset serial/busy got %b/%b exp 1/0", tx_serial, tx_busy);
      end
   endtask

   task automatic test_single_byte();
      int reads = 0;
      int dones = 0;
      tx_data = 8'hA5; tx_valid = 1'b1;
      for (int c = 0; c <= FRAME; c++) begin
         @(negedge clk);
         if (tx_read === 1'b1) reads++;
         if (tx_done === 1'b1) dones++;
         if (c < FRAME) begin
            n_tests++;
            if (tx_serial !== exp_bit(8'hA5, 1'b0, c / CPB)) begin
               n_fail++; $display("FAIL single serial c=%0d got %b exp %b", c, tx_serial, exp_bit(8'hA5, 1'b0, c / CPB));
            end
         end
         if (c == 0) begin
            n_tests++; if (tx_read !== 1'b1) begin n_fail++; $display("FAIL single first_read got %b exp 1", tx_read); end
            tx_valid = 1'b0;
         end
         if (c == 20) begin
            n_tests++; if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL single busy got %b exp 1", tx_busy); end
         end
         if (c == FRAME) begin
            n_tests++; if (tx_done !== 1'b1) begin n_fail++; $display("FAIL single done got %b exp 1", tx_done); end
            n_tests++; if (tx_busy !== 1'b0 || tx_serial !== 1'b1) begin
               n_fail++; $display("FAIL single end busy/serial got %b/%b exp 0/1", tx_busy, tx_serial);
            end
         end
      end
      n_tests++; if (reads != 1) begin n_fail++; $display("FAIL single read_count got %0d exp 1", reads); end
      n_tests++; if (dones != 1) begin n_fail++; $display("FAIL single done_count got %0d exp 1", dones); end
   endtask

   task automatic test_back_to_back();
      int reads = 0;
      int rd1 = -1;
      int rd2 = -1;
      logic e;
      tx_data = 8'h00; tx_valid = 1'b1;
      for (int c = 0; c <= 2 * FRAME; c++) begin
         @(negedge clk);
         if (tx_read === 1'b1) begin
            reads++;
            if (rd1 < 0) rd1 = c; else rd2 = c;
         end
         if (c < 2 * FRAME) begin
            e = (c < FRAME) ? exp_bit(8'h00, 1'b0, c / CPB) : exp_bit(8'hFF, 1'b0, (c - FRAME) / CPB);
            n_tests++;
            if (tx_serial !== e) begin n_fail++; $display("FAIL b2b serial c=%0d got %b exp %b", c, tx_serial, e); end
         end
         if (c == 0) tx_data = 8'hFF;
         if (c == FRAME) begin
            n_tests++; if (tx_done !== 1'b1 || tx_busy !== 1'b1) begin
               n_fail++; $display("FAIL b2b mid done/busy got %b/%b exp 1/1", tx_done, tx_busy);
            end
            tx_valid = 1'b0;
         end
         if (c == 2 * FRAME) begin
            n_tests++; if (tx_done !== 1'b1 || tx_busy !== 1'b0) begin
               n_fail++; $display("FAIL b2b end done/busy got %b/%b exp 1/0", tx_done, tx_busy);
            end
         end
      end
      n_tests++; if (reads != 2 || rd1 != 0 || rd2 != FRAME) begin
         n_fail++; $display("FAIL b2b reads got %0d at %0d,%0d exp 2 at 0,%0d", reads, rd1, rd2, FRAME);
      end
   endtask

   task automatic test_bist_mid_frame();
      tx_data = 8'h3C; tx_valid = 1'b1; bist = 1'b0;
      for (int c = 0; c <= FRAME; c++) begin
         @(negedge clk);
         if (c < FRAME) begin
            n_tests++;
            if (tx_serial !== exp_bit(8'h3C, 1'b0, c / CPB)) begin
               n_fail++; $display("FAIL bist serial c=%0d got %b exp %b", c, tx_serial, exp_bit(8'h3C, 1'b0, c / CPB));
            end
         end
         if (c == 10) bist = 1'b1;
         if (c == FRAME) begin
            n_tests++; if (tx_done !== 1'b1 || tx_busy !== 1'b0 || tx_serial !== 1'b1) begin
               n_fail++; $display("FAIL bist end done/busy/serial got %b/%b/%b exp 1/0/1", tx_done, tx_busy, tx_serial);
            end
         end
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         n_tests++; if (tx_read !== 1'b0 || tx_serial !== 1'b1 || tx_busy !== 1'b0) begin
            n_fail++; $display("FAIL bist hold i=%0d read/serial/busy got %b/%b/%b exp 0/1/0", i, tx_read, tx_serial, tx_busy);
         end
      end
      bist = 1'b0;
      @(negedge clk);
      n_tests++; if (tx_read !== 1'b1 || tx_serial !== 1'b0 || tx_busy !== 1'b1) begin
         n_fail++; $display("FAIL bist release read/serial/busy got %b/%b/%b exp 1/0/1", tx_read, tx_serial, tx_busy);
      end
      tx_valid = 1'b0;
      repeat (FRAME) @(negedge clk);
      n_tests++; if (tx_done !== 1'b1) begin n_fail++; $display("FAIL bist second_done got %b exp 1", tx_done); end
   endtask

   task automatic test_reset_mid_frame();
      int dones = 0;
      tx_data = 8'h5A; tx_valid = 1'b1;
      for (int c = 0; c <= 6; c++) begin
         @(negedge clk);
         if (c == 0) tx_valid = 1'b0;
      end
      n_tests++; if (tx_serial !== 1'b0) begin n_fail++; $display("FAIL rstmid pre serial got %b exp 0", tx_serial); end
      #1 rst = 1'b1;
      #1;
      n_tests++; if (tx_serial !== 1'b1 || tx_busy !== 1'b0 || tx_read !== 1'b0) begin
         n_fail++; $display("FAIL rstmid async serial/busy/read got %b/%b/%b exp 1/0/0", tx_serial, tx_busy, tx_read);
      end
      repeat (2) begin
         @(negedge clk);
         if (tx_done === 1'b1) dones++;
      end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (tx_done === 1'b1) dones++;
      end
      n_tests++; if (dones != 0 || tx_busy !== 1'b0 || tx_serial !== 1'b1) begin
         n_fail++; $display("FAIL rstmid after dones/busy/serial got %0d/%b/%b exp 0/0/1", dones, tx_busy, tx_serial);
      end
      tx_data = 8'h96; tx_valid = 1'b1;
      for (int c = 0; c <= FRAME; c++) begin
         @(negedge clk);
         if (c == 0) tx_valid = 1'b0;
         if (c < FRAME) begin
            n_tests++;
            if (tx_serial !== exp_bit(8'h96, 1'b0, c / CPB)) begin
               n_fail++; $display("FAIL rstmid clean serial c=%0d got %b exp %b", c, tx_serial, exp_bit(8'h96, 1'b0, c / CPB));
            end
         end else begin
            n_tests++; if (tx_done !== 1'b1) begin n_fail++; $display("FAIL rstmid clean done got %b exp 1", tx_done); end
         end
      end
   endtask

   task automatic test_odd_parity();
      tx_data2 = 8'h01; tx_valid2 = 1'b1;
      for (int c = 0; c <= FRAME; c++) begin
         @(negedge clk);
         if (c == 0) tx_valid2 = 1'b0;
         if (c < FRAME) begin
            n_tests++;
            if (tx_serial2 !== exp_bit(8'h01, 1'b1, c / CPB)) begin
               n_fail++; $display("FAIL odd serial c=%0d got %b exp %b", c, tx_serial2, exp_bit(8'h01, 1'b1, c / CPB));
            end
         end else begin
            n_tests++; if (tx_done2 !== 1'b1) begin n_fail++; $display("FAIL odd done got %b exp 1", tx_done2); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_byte();
      repeat (3) @(negedge clk);
      test_back_to_back();
      repeat (3) @(negedge clk);
      test_bist_mid_frame();
      repeat (3) @(negedge clk);
      test_reset_mid_frame();
      repeat (3) @(negedge clk);
      test_odd_parity();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout after %0d tests", n_tests);
      $fatal(1, "timeout");
   end

endmodule
